// File: rtl/flash_dspi_responder.sv
// Target side of a dual-IO fast read (0xBB) that streams 16-bit words from a backing memory.
// Define FLASH_CONT_READ_EN to honour the continuous-read mode bits (M[5:4] == 2'b10).
module flash_dspi_responder #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_cs,
    input  logic [1:0]  spi_io_in,
    output logic [1:0]  spi_io_out,
    output logic [1:0]  spi_io_oe,
    output logic        mem_rd,
    output logic [21:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        cont_mode
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DATA, IGNORE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [6:0]  cmd_sr;
    logic [23:0] addr_sr;
    logic [7:0]  mode_sr;
    logic [15:0] data_sr;
    logic [7:0]  cmd_full;
    logic [23:0] addr_full;
    logic        unused_bits;

    // Values including the bit(s) being sampled on the current edge.
    assign cmd_full  = {cmd_sr, spi_io_in[0]};
    assign addr_full = {addr_sr[21:0], spi_io_in};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!spi_cs) state_d = cont_mode ? ADDR : CMD;
            CMD: begin
                if (spi_cs)              state_d = IDLE;
                else if (cnt == 4'd7)    state_d = (cmd_full == 8'hBB) ? ADDR : IGNORE;
            end
            ADDR: begin
                if (spi_cs)              state_d = IDLE;
                else if (cnt == 4'd11)   state_d = MODE;
            end
            MODE: begin
                if (spi_cs)              state_d = IDLE;
                else if (cnt == 4'd3)    state_d = DATA;
            end
            DATA:    if (spi_cs) state_d = IDLE;
            IGNORE:  if (spi_cs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: cnt counts samples within the current phase; the IDLE edge already takes sample 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= 4'd0;
            cmd_sr   <= 7'd0;
            addr_sr  <= 24'd0;
            mode_sr  <= 8'd0;
            data_sr  <= 16'd0;
            mem_rd   <= 1'b0;
            mem_addr <= 22'd0;
        end else begin
            mem_rd <= 1'b0;
            if (spi_cs) begin
                cnt <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt <= 4'd1;
                        if (cont_mode) addr_sr <= addr_full;
                        else           cmd_sr  <= {cmd_sr[5:0], spi_io_in[0]};
                    end
                    CMD: begin
                        cmd_sr <= {cmd_sr[5:0], spi_io_in[0]};
                        cnt    <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                    end
                    ADDR: begin
                        addr_sr <= addr_full;
                        if (cnt == 4'd11) begin
                            cnt      <= 4'd0;
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_full[22:1];
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    MODE: begin
                        mode_sr <= {mode_sr[5:0], spi_io_in};
                        if (cnt == 4'd3) begin
                            cnt      <= 4'd0;
                            data_sr  <= mem_rdata;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 22'd1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        // Last dibit of a word: load the prefetched word and issue the next prefetch.
                        if (cnt == 4'd7) begin
                            cnt      <= 4'd0;
                            data_sr  <= mem_rdata;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 22'd1;
                        end else begin
                            cnt     <= cnt + 4'd1;
                            data_sr <= {data_sr[13:0], 2'b00};
                        end
                    end
                    default: cnt <= 4'd0;
                endcase
            end
        end
    end

`ifdef FLASH_CONT_READ_EN
    // mode_sr[3:2] holds M[5:4] on the edge that samples M[1:0].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cont_mode <= 1'b0;
        end else if (state_q == MODE && !spi_cs && cnt == 4'd3) begin
            cont_mode <= (mode_sr[3:2] == 2'b10);
        end
    end
`else
    assign cont_mode = 1'b0;
`endif

    assign spi_io_oe   = (state_q == DATA && !spi_cs) ? 2'b11 : 2'b00;
    assign spi_io_out  = (state_q == DATA) ? data_sr[15:14] : 2'b00;
    assign unused_bits = ^{addr_sr[23:22], addr_full[23], addr_full[0], mode_sr, (MEM_LATENCY > 3)};

endmodule

// File: tb/tb_flash_dspi_responder.sv
// Directed bench for flash_dspi_responder: table of dual-IO read transactions plus abort, reset and mode sequences.
module tb_flash_dspi_responder;

    localparam int LAT = 3;
`ifdef FLASH_CONT_READ_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        spi_cs;
    logic [1:0]  spi_io_in;
    logic [1:0]  spi_io_out;
    logic [1:0]  spi_io_oe;
    logic        mem_rd;
    logic [21:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        cont_mode;

    int total = 0;
    int bad = 0;

    logic        cap_rd   [0:47];
    logic [21:0] cap_addr [0:47];
    logic [1:0]  cap_oe   [0:47];
    logic [1:0]  cap_out  [0:47];
    logic        cap_cont [0:47];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  m;
        bit          hit;
        logic [21:0] exp_a0;
        logic [21:0] exp_a1;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
    } vec_t;

    vec_t vecs [0:4];

    flash_dspi_responder #(.MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .spi_cs     (spi_cs),
        .spi_io_in  (spi_io_in),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .cont_mode  (cont_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [21:0] a);
        case (a)
            22'h000080: return 16'hA55A;
            22'h000081: return 16'h1234;
            22'h000082: return 16'hBEEF;
            22'h3FFFFF: return 16'hC3C3;
            22'h000000: return 16'h0F0F;
            default:    return 16'h0000;
        endcase
    endfunction

    // Backing memory: data appears LAT clocks after the mem_rd cycle and holds until the next read.
    logic [21:0] pend_addr = 22'd0;
    int          pend_cnt = 0;
    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            pend_addr = mem_addr;
            pend_cnt  = LAT;
        end
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) mem_rdata <= mem_val(pend_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step(input logic cs, input logic [1:0] io, input int k);
        @(negedge clk);
        spi_cs    = cs;
        spi_io_in = io;
        #1;
        cap_rd[k]   = mem_rd;
        cap_addr[k] = mem_addr;
        cap_oe[k]   = spi_io_oe;
        cap_out[k]  = spi_io_out;
        cap_cont[k] = cont_mode;
    endtask

    task automatic drive_k(input bit with_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [7:0] m, input int k);
        int          p;
        logic [1:0]  io;
        logic [7:0]  c;
        logic [23:0] a;
        logic [7:0]  mm;
        p  = with_cmd ? k - 8 : k;
        io = 2'b00;
        if (with_cmd && k < 8) begin
            c  = cmd << k;
            io = {1'b0, c[7]};
        end else if (p >= 0 && p < 12) begin
            a  = addr << (2 * p);
            io = a[23:22];
        end else if (p >= 12 && p < 16) begin
            mm = m << (2 * (p - 12));
            io = mm[7:6];
        end
        step(1'b0, io, k);
    endtask

    // nclk cycles with chip select low (k = 0..nclk-1), then one deselected cycle captured at index nclk.
    task automatic run_txn(input bit with_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [7:0] m, input int nclk);
        for (int k = 0; k < nclk; k++) drive_k(with_cmd, cmd, addr, m, k);
        step(1'b1, 2'b00, nclk);
    endtask

    function automatic logic [15:0] word_at(input int s);
        logic [15:0] w;
        w = 16'h0000;
        for (int j = 0; j < 8; j++) w = {w[13:0], cap_out[s + j]};
        return w;
    endfunction

    task automatic check_txn(input int idx, input vec_t v);
        int   rd_err;
        int   oe_err;
        logic exp_rd;
        logic [1:0] exp_oe;
        rd_err = 0;
        oe_err = 0;
        for (int k = 0; k < 40; k++) begin
            exp_rd = v.hit && (k == 20 || k == 24 || k == 32);
            exp_oe = (v.hit && k >= 24) ? 2'b11 : 2'b00;
            if (cap_rd[k] !== exp_rd) rd_err++;
            if (cap_oe[k] !== exp_oe) oe_err++;
        end
        chk($sformatf("v%0d_rd_pattern_errs", idx), rd_err, 0);
        chk($sformatf("v%0d_oe_pattern_errs", idx), oe_err, 0);
        if (v.hit) begin
            chk($sformatf("v%0d_addr_k20", idx), cap_addr[20], v.exp_a0);
            chk($sformatf("v%0d_addr_k24", idx), cap_addr[24], v.exp_a1);
            chk($sformatf("v%0d_word0", idx), word_at(24), v.exp_w0);
            chk($sformatf("v%0d_word1", idx), word_at(32), v.exp_w1);
        end
        chk($sformatf("v%0d_cont", idx), cap_cont[40], 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hBB, 24'h000100, 8'h00, 1'b1, 22'h000080, 22'h000081, 16'hA55A, 16'h1234};
        vecs[1] = '{8'hBB, 24'h800103, 8'hFF, 1'b1, 22'h000081, 22'h000082, 16'h1234, 16'hBEEF};
        vecs[2] = '{8'h03, 24'h000100, 8'h00, 1'b0, 22'h0, 22'h0, 16'h0, 16'h0};
        vecs[3] = '{8'hBA, 24'h000100, 8'h00, 1'b0, 22'h0, 22'h0, 16'h0, 16'h0};
        vecs[4] = '{8'hBB, 24'h7FFFFE, 8'h10, 1'b1, 22'h3FFFFF, 22'h000000, 16'hC3C3, 16'h0F0F};

        resetn    = 1'b0;
        spi_cs    = 1'b1;
        spi_io_in = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_oe", spi_io_oe, 2'b00);
        chk("reset_out", spi_io_out, 2'b00);
        chk("reset_rd", mem_rd, 1'b0);
        chk("reset_addr", mem_addr, 22'd0);
        chk("reset_cont", cont_mode, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 2'b00, 0);

        for (int i = 0; i < 5; i++) begin
            run_txn(1'b1, vecs[i].cmd, vecs[i].addr, vecs[i].m, 40);
            check_txn(i, vecs[i]);
        end

        // Abort in the middle of the first data word, then an immediate restart.
        run_txn(1'b1, 8'hBB, 24'h000100, 8'h00, 27);
        chk("abort_oe_k26", cap_oe[26], 2'b11);
        chk("abort_oe_k27", cap_oe[27], 2'b00);
        run_txn(1'b1, 8'hBB, 24'h000100, 8'h00, 40);
        check_txn(5, vecs[0]);

        // Asynchronous reset while driving data at k=26.
        for (int k = 0; k < 27; k++) drive_k(1'b1, 8'hBB, 24'h000100, 8'h20, k);
        chk("prerst_oe", cap_oe[26], 2'b11);
        chk("prerst_out", cap_out[26], 2'b01);
        chk("prerst_cont", cap_cont[26], CONT_EN);
        #2 resetn = 1'b0;
        #1;
        chk("rst_oe", spi_io_oe, 2'b00);
        chk("rst_out", spi_io_out, 2'b00);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 22'd0);
        chk("rst_cont", cont_mode, 1'b0);
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 2'b00, 0);
        run_txn(1'b1, 8'hBB, 24'h800103, 8'h00, 40);
        check_txn(6, vecs[1]);

`ifdef FLASH_CONT_READ_EN
        run_txn(1'b1, 8'hBB, 24'h000100, 8'h20, 40);
        chk("cm_cont_k23", cap_cont[23], 1'b0);
        chk("cm_cont_k24", cap_cont[24], 1'b1);
        chk("cm_word0", word_at(24), 16'hA55A);
        // Command-less transaction: every phase arrives 8 clocks earlier.
        run_txn(1'b0, 8'h00, 24'h7FFFFE, 8'h20, 32);
        chk("cm_rd_k12", cap_rd[12], 1'b1);
        chk("cm_addr_k12", cap_addr[12], 22'h3FFFFF);
        chk("cm_rd_k16", cap_rd[16], 1'b1);
        chk("cm_addr_k16", cap_addr[16], 22'h000000);
        chk("cm_word_k16", word_at(16), 16'hC3C3);
        chk("cm_oe_k16", cap_oe[16], 2'b11);
        chk("cm_still_cont", cap_cont[32], 1'b1);
        run_txn(1'b0, 8'h00, 24'h555555, 8'h55, 16);
        chk("cm_exit_cont", cap_cont[16], 1'b0);
        run_txn(1'b1, 8'hBB, 24'h000100, 8'h00, 40);
        check_txn(7, vecs[0]);
`else
        run_txn(1'b1, 8'hBB, 24'h000100, 8'h20, 40);
        chk("nocm_cont", cap_cont[40], 1'b0);
        chk("nocm_word0", word_at(24), 16'hA55A);
        run_txn(1'b1, 8'hBB, 24'h800103, 8'h20, 40);
        check_txn(7, vecs[1]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
